aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for the iterative AES-128 key-expansion step datapath.
- Accepts a cipher key via valid/ready and drives the step datapath with the previous round key and round number for rounds 1..10.
- Samples each result after a fixed latency and stores all 11 round keys in a register file.
- The cipher core reads round keys from this file through a registered read port.

Parameters:
- STEP_LAT, 2, cycles from stable step inputs to a valid step_result (must be >=1)
- NUM_ROUNDS, 10, number of expansion rounds (AES-128)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- key_in  in  128  cipher key, word 0 in [127:96]
- key_valid  in  1  key_in valid
- key_ready  out  1  block can accept a key
- step_key  out  128  previous round key to the step datapath
- step_round  out  4  round number to the step datapath (1..10; 0 when idle)
- step_result  in  128  next round key from the step datapath
- rk_rd_addr  in  4  round-key read index 0..10
- rk_rd_data  out  128  registered read data
- keys_valid  out  1  all 11 round keys stored and consistent
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when round 10 is stored

Behaviour:
- Reset (async, rst=0) forces the following, overriding everything including mid-expansion:
  - state=IDLE, round=0, wait count=0
  - step_key=0, step_round=0, rk_rd_data=0
  - keys_valid=0, busy=0, done=0, key_ready=1
  - all 11 round-key registers cleared to 0
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: key_ready=1. On key_valid&&key_ready: rk[0]<=key_in, round<=1, keys_valid<=0, go to ISSUE.
  - ISSUE (1 cycle): step_key<=rk[round-1], step_round<=round, cnt<=0, go to WAIT. These outputs are registered and held stable through WAIT.
  - WAIT (STEP_LAT cycles): cnt increments each cycle. On the cycle with cnt==STEP_LAT-1, rk[round]<=step_result.
    - If round==NUM_ROUNDS: go to DONE, keys_valid<=1, done<=1 for one cycle, busy<=0, step_round<=0.
    - Else: round<=round+1, go to ISSUE.
  - DONE: key_ready=1, keys_valid=1. On an accepted new key, behave as in IDLE (rk[0] overwritten, keys_valid<=0 on the same edge, go to ISSUE).
- key_ready=0 in ISSUE and WAIT; key_valid is ignored there and no key is lost or queued. The requester must hold key_valid.
- busy=1 in ISSUE and WAIT only.
- Latency: round-10 key stored, keys_valid and done asserted exactly NUM_ROUNDS*(STEP_LAT+1) cycles after the accept edge (30 at default).
- Read port: rk_rd_data<=rk[rk_rd_addr] every cycle (1-cycle latency).
  - rk_rd_addr>10 returns 0.
  - Reads during expansion return the current register contents (stale or partial); consumers must qualify reads with keys_valid.
  - A read of an index written on the same edge returns the old value; the new value appears on the following cycle.
- Round counter is 4 bits and never exceeds NUM_ROUNDS; no wrap-around.
- step_result is sampled only at the capture cycle; its value at all other times is don't-care.

Decomposition:
- Package aes_pkg holds:
  - NUM_ROUNDS=10
  - typedef for the 128-bit round key
  - FSM state enum (IDLE, ISSUE, WAIT, DONE)
  - RCON table 01,02,04,08,10,20,40,80,1B,36, shared with the step datapath
- Sub-module aes_rk_store: 11x128 register file with one write port (we, waddr, wdata), one registered read port and async clear. The FSM lives in aes_key_sched_ctrl.

Test Plan:
- Reset then idle: after reset release, key_ready=1, keys_valid=0, busy=0, rk_rd_data=0 for all addresses.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a behavioural step model at STEP_LAT=2 -> done pulse exactly 30 cycles after accept; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; step_round sequences 1..10.
- key_valid held high with a second key during WAIT -> key_ready=0 and the key is not accepted. When DONE is reached, the second key is accepted on the next edge, keys_valid drops on that edge, and the new rk[10] matches the reference model.
- Assert rst=0 during round 5 WAIT -> all outputs and round-key registers return to reset values immediately. After release, a new key expands correctly from round 1.
- Read rk_rd_addr=0..15 after done -> data appears one cycle after the address; addresses 11..15 return 0.
- STEP_LAT=1 and STEP_LAT=4 builds -> done occurs at 20 and 50 cycles after accept; step_key is stable for the whole WAIT window (checked by assertion).

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : aes_pkg                                                      |
// | Description : Shared AES-128 key-schedule definitions: round count,        |
// |               round-key type, sequencer state encoding and the RCON table  |
// |               used by the external key-expansion step datapath.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int RK_W       = 128;

  typedef logic [RK_W-1:0] rk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ks_state_e;

  // Round constants for rounds 1..10 (index 0 is round 1).
  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

  // Round constant lookup for a 1-based round number; 0 outside 1..10.
  function automatic logic [7:0] rcon_for(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (round == 4'(i + 1)) begin
        r = RCON[i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_rk_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_rk_store                                                 |
// | Description : Round-key register file with one write port, one registered |
// |               read port and one combinational peek port used by the       |
// |               sequencer to fetch the previous round key.                  |
// | Ports       : clk, rst_n (async, active-low clear of every entry)         |
// |               we/waddr/wdata   - write port                               |
// |               rd_addr/rd_data  - registered read, 0 for addr >= DEPTH     |
// |               peek_addr/peek_data - combinational read, 0 out of range    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_rk_store #(
  parameter int DEPTH = aes_pkg::NUM_ROUNDS + 1,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [127:0]  rd_data,
  input  logic [AW-1:0] peek_addr,
  output logic [127:0]  peek_data
);
  import aes_pkg::*;

  rk_t entry_q [DEPTH];
  rk_t entry_d [DEPTH];
  rk_t rd_data_q;
  rk_t rd_data_d;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (we && (waddr == AW'(i))) begin
        entry_d[i] = wdata;
      end
    end
  end

  // Reads decode against the current contents, so a read of an entry being
  // written on the same edge returns the old value.
  always_comb begin
    rd_data_d = '0;
    peek_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data_d = entry_q[i];
      end
      if (peek_addr == AW'(i)) begin
        peek_data = entry_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_key_sched_ctrl                                           |
// | Description : Sequencer for the iterative AES-128 key-expansion step      |
// |               datapath. Accepts a key, issues rounds 1..NUM_ROUNDS to the |
// |               step datapath, captures each result STEP_LAT cycles later   |
// |               and stores all round keys for the cipher core.              |
// | Ports       : clk, rst (async, active-low)                                |
// |               key_in/key_valid/key_ready - key intake handshake           |
// |               step_key/step_round/step_result - step datapath interface   |
// |               rk_rd_addr/rk_rd_data - registered round-key read port      |
// |               keys_valid, busy, done - status                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_key_sched_ctrl #(
  parameter int STEP_LAT   = 2,
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] step_key,
  output logic [3:0]   step_round,
  input  logic [127:0] step_result,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         keys_valid,
  output logic         busy,
  output logic         done
);
  import aes_pkg::*;

  localparam int          CNT_W      = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_LAT - 1);

  ks_state_e        state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rk_t              step_key_q, step_key_d;
  logic [3:0]       step_round_q, step_round_d;
  logic             keys_valid_q, keys_valid_d;
  logic             done_q, done_d;

  logic       wr_en;
  logic [3:0] wr_addr;
  rk_t        wr_data;
  logic [3:0] peek_addr;
  rk_t        peek_data;

  // The key feeding round N is always round key N-1.
  assign peek_addr = round_q - 4'd1;

  aes_rk_store #(
    .DEPTH (NUM_ROUNDS + 1),
    .AW    (4)
  ) u_rk_store (
    .clk       (clk),
    .rst_n     (rst),
    .we        (wr_en),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .rd_addr   (rk_rd_addr),
    .rd_data   (rk_rd_data),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    step_key_d   = step_key_q;
    step_round_d = step_round_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = round_q;
    wr_data      = step_result;

    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          wr_en        = 1'b1;
          wr_addr      = 4'd0;
          wr_data      = key_in;
          round_d      = 4'd1;
          keys_valid_d = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Step inputs are registered here and held untouched through WAIT.
        step_key_d   = peek_data;
        step_round_d = round_q;
        cnt_d        = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          wr_en   = 1'b1;
          wr_addr = round_q;
          if (round_q == LAST_ROUND) begin
            state_d      = DONE;
            keys_valid_d = 1'b1;
            done_d       = 1'b1;
            step_round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      round_q      <= 4'd0;
      cnt_q        <= '0;
      step_key_q   <= '0;
      step_round_q <= 4'd0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      step_key_q   <= step_key_d;
      step_round_q <= step_round_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
    end
  end

  assign key_ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign step_key   = step_key_q;
  assign step_round = step_round_q;
  assign keys_valid = keys_valid_q;
  assign done       = done_q;

endmodule
`default_nettype wire
